sync_fifo_prog: RTL

Parametrised synchronous FIFO. It is the RTL successor to the team's fixed-depth FIFO.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a read-valid strobe.
- Fully legal simultaneous read/write at the full and empty boundaries.
- Sits between a producer and a consumer in the same clock domain. It is checked against a queue-based model in the class-based testbench.

---
 rtl/sync_fifo_prog.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
//   Parametrised single-clock FIFO. It has programmable almost-full and
//   almost-empty thresholds, an occupancy count, a synchronous flush and a
//   read-valid strobe. A read and a write in the same cycle are legal at both
//   the full and the empty boundary. There is no fall-through: a word written
//   into an empty FIFO can be read at the earliest on the next cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (priority over everything)
//   flush       synchronous clear of contents; data_out is left untouched
//   wr_en       write request, data_in is the write word
//   rd_en       read request
//   data_out    registered read data, valid when rd_valid is high
//   rd_valid    data_out holds a word popped on the previous edge
//   wr_ack      write on the previous edge was accepted
//   overflow    write on the previous edge was rejected (FIFO full)
//   underflow   read on the previous edge was rejected (FIFO empty)
//   full / almostfull / empty / almostempty
//               status flags decoded from the registered count
//   count       current occupancy, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(FIFO_DEPTH - 1);

  // Depth need not be a power of two, so pointers wrap on an explicit
  // compare against the last index instead of relying on natural rollover.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST_C) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Storage and state registers
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic [FIFO_WIDTH-1:0] dout_q,   dout_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ack_q,   wr_ack_d;
  logic                  ovf_q,      ovf_d;
  logic                  udf_q,      udf_d;

  // Decoded status and acceptance
  logic full_s;
  logic empty_s;
  logic rd_acc_s;
  logic wr_acc_s;

  // Status flags decode straight from the registered count.
  always_comb begin
    full_s      = (count_q == DEPTH_C);
    empty_s     = (count_q == CNT_W'(0));
    full        = full_s;
    empty       = empty_s;
    almostfull  = (count_q >= AF_C) && !full_s;
    almostempty = (count_q <= AE_C) && !empty_s;
  end

  // Acceptance is decided on the pre-edge count. A read frees a slot in the
  // same edge, so a full FIFO can still take a write alongside a read; an
  // empty FIFO cannot be read even with a concurrent write. Flush kills both.
  always_comb begin
    rd_acc_s = rd_en && !empty_s && !flush;
    wr_acc_s = wr_en && (!full_s || rd_acc_s) && !flush;
  end

  // Next-state computation for pointers, count, read data and pulses.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    wr_ack_d   = 1'b0;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;
    if (flush) begin
      // Contents and pulses cleared; data_out deliberately holds.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (rd_acc_s) begin
        dout_d   = mem_q[rd_ptr_q];
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (wr_acc_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      rd_valid_d = rd_acc_s;
      wr_ack_d   = wr_acc_s;
      ovf_d      = wr_en && !wr_acc_s;
      udf_d      = rd_en && !rd_acc_s;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = dout_q;
  assign rd_valid  = rd_valid_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign count     = count_q;

endmodule
